// File: rtl/instr_encoder_loader_pkg.sv
// instr_encoder_loader_pkg: shared format codes, RV32I opcodes, FSM states and immediate range helper
package instr_encoder_loader_pkg;
  localparam logic [2:0] FMT_I = 3'd0;
  localparam logic [2:0] FMT_S = 3'd1;
  localparam logic [2:0] FMT_B = 3'd2;
  localparam logic [2:0] FMT_U = 3'd3;
  localparam logic [2:0] FMT_J = 3'd4;
  localparam logic [2:0] FMT_R = 3'd5;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_OP     = 7'h33;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FIN} state_t;
  // True when v is the sign extension of its low n bits (bits [31:n-1] all equal).
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned n);
    logic [31:0] s;
    s = $signed(v) >>> (n - 1);
    return (s == '0) || (s == '1);
  endfunction
endpackage

// File: rtl/instr_encoder_loader_pack.sv
// instr_pack: combinational packing of decoded fields into an RV32I word with a legality flag
module instr_pack
  import instr_encoder_loader_pkg::*;
(
  input  logic [2:0]  i_fmt,
  input  logic [6:0]  i_opcode,
  input  logic [2:0]  i_funct3,
  input  logic [6:0]  i_funct7,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [31:0] i_imm,
  output logic [31:0] o_word,
  output logic        o_legal
);
  // Select the bit layout and range rule for the requested format; unknown formats stay illegal
  always_comb begin
    o_word  = '0;
    o_legal = 1'b0;
    case (i_fmt)
      FMT_I: begin
        o_word  = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
        o_legal = fits_signed(i_imm, 12);
      end
      FMT_S: begin
        o_word  = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
        o_legal = fits_signed(i_imm, 12);
      end
      FMT_B: begin
        o_word  = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3, i_imm[4:1], i_imm[11], i_opcode};
        o_legal = fits_signed(i_imm, 13) && !i_imm[0];
      end
      FMT_U: begin
        o_word  = {i_imm[31:12], i_rd, i_opcode};
        o_legal = i_imm[11:0] == '0;
      end
      FMT_J: begin
        o_word  = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
        o_legal = fits_signed(i_imm, 21) && !i_imm[0];
      end
      FMT_R: begin
        o_word  = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
        o_legal = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: streams decoded instruction fields into packed words written to consecutive memory words
module instr_encoder_loader
  import instr_encoder_loader_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic              i_in_last,
  input  logic [2:0]        i_in_fmt,
  input  logic [6:0]        i_in_opcode,
  input  logic [2:0]        i_in_funct3,
  input  logic [6:0]        i_in_funct7,
  input  logic [4:0]        i_in_rd,
  input  logic [4:0]        i_in_rs1,
  input  logic [4:0]        i_in_rs2,
  input  logic [31:0]       i_in_imm,
  output logic              o_mem_we,
  input  logic              i_mem_ready,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [CNT_W-1:0]  o_word_count,
  output logic [CNT_W-1:0]  o_err_count
);
  state_t              r_state, w_next;
  logic [ADDR_W-1:0]   r_addr, r_mem_addr;
  logic [31:0]         r_mem_wdata, w_word;
  logic                r_mem_we, r_err, w_legal, w_fire, w_wdone, w_load, w_begin;
  logic [CNT_W-1:0]    r_word_count, r_err_count;

  instr_pack u_pack (
    .i_fmt(i_in_fmt), .i_opcode(i_in_opcode), .i_funct3(i_in_funct3), .i_funct7(i_in_funct7),
    .i_rd(i_in_rd), .i_rs1(i_in_rs1), .i_rs2(i_in_rs2), .i_imm(i_in_imm),
    .o_word(w_word), .o_legal(w_legal)
  );

  assign o_in_ready = (r_state == S_RUN) && (!r_mem_we || i_mem_ready);
  assign w_fire     = i_in_valid && o_in_ready;
  assign w_wdone    = r_mem_we && i_mem_ready;
  assign w_load     = w_fire && w_legal;
  assign w_begin    = (r_state == S_IDLE) && i_start;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next state: a rejected last beat also ends the session; DRAIN waits for the output register to empty
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = i_start ? S_RUN : S_IDLE;
      S_RUN:   w_next = (w_fire && i_in_last) ? S_DRAIN : S_RUN;
      S_DRAIN: w_next = r_mem_we ? S_DRAIN : S_FIN;
      default: w_next = S_IDLE;
    endcase
  end

  // Output register and next-write address: reloads on a legal beat, empties when a write completes alone
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr      <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      if (w_begin)     r_addr <= i_base_addr & ~ADDR_W'(3);
      else if (w_load) r_addr <= r_addr + ADDR_W'(4);
      if (w_load) begin
        r_mem_we    <= 1'b1;
        r_mem_addr  <= r_addr;
        r_mem_wdata <= w_word;
      end else if (w_wdone) begin
        r_mem_we    <= 1'b0;
      end
    end
  end

  // Session statistics: cleared by an accepted start, counters saturate at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word_count <= '0;
      r_err_count  <= '0;
      r_err        <= 1'b0;
    end else if (w_begin) begin
      r_word_count <= '0;
      r_err_count  <= '0;
      r_err        <= 1'b0;
    end else begin
      if (w_wdone && ~&r_word_count) r_word_count <= r_word_count + CNT_W'(1);
      if (w_fire && !w_legal) begin
        r_err <= 1'b1;
        if (~&r_err_count) r_err_count <= r_err_count + CNT_W'(1);
      end
    end
  end

  assign o_mem_we     = r_mem_we;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_wdata  = r_mem_wdata;
  assign o_busy       = r_state != S_IDLE;
  assign o_done       = r_state == S_FIN;
  assign o_err        = r_err;
  assign o_word_count = r_word_count;
  assign o_err_count  = r_err_count;
endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb_instr_encoder_loader: directed-vector bench for the instruction encoder/loader
module tb_instr_encoder_loader;
  import instr_encoder_loader_pkg::*;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        start = 1'b0, in_valid = 1'b0, in_last = 1'b0, mem_ready = 1'b1;
  logic [31:0] base_addr = '0, imm = '0;
  logic [2:0]  fmt = '0, funct3 = '0;
  logic [6:0]  opcode = '0, funct7 = '0;
  logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
  logic        in_ready, mem_we, busy, done, err;
  logic [31:0] mem_addr, mem_wdata;
  logic [15:0] word_count, err_count;
  int checks = 0, failures = 0;

  instr_encoder_loader #(.ADDR_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_base_addr(base_addr),
    .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_last(in_last),
    .i_in_fmt(fmt), .i_in_opcode(opcode), .i_in_funct3(funct3), .i_in_funct7(funct7),
    .i_in_rd(rd), .i_in_rs1(rs1), .i_in_rs2(rs2), .i_in_imm(imm),
    .o_mem_we(mem_we), .i_mem_ready(mem_ready), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .o_busy(busy), .o_done(done), .o_err(err), .o_word_count(word_count), .o_err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic beat(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2, input logic [31:0] im,
                      input logic last);
    fmt = f; opcode = op; funct3 = f3; funct7 = f7; rd = d; rs1 = s1; rs2 = s2; imm = im; in_last = last;
    in_valid = 1'b1;
  endtask

  task automatic begin_session(input logic [31:0] base);
    @(negedge clk); start = 1'b1; base_addr = base;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if ({mem_we, in_ready, busy, done, err} !== 5'b0) begin failures++; $display("FAIL reset_flags got %b exp 00000", {mem_we, in_ready, busy, done, err}); end
    checks++; if ({mem_addr, mem_wdata} !== 64'h0) begin failures++; $display("FAIL reset_regs got %h exp 0", {mem_addr, mem_wdata}); end
    checks++; if ({word_count, err_count} !== 32'h0) begin failures++; $display("FAIL reset_counts got %h exp 0", {word_count, err_count}); end
    rst_n = 1'b1;
  endtask

  task automatic test_single_i;
    begin_session(32'h100);
    checks++; if ({busy, in_ready} !== 2'b11) begin failures++; $display("FAIL run_entry got %b exp 11", {busy, in_ready}); end
    beat(FMT_I, OP_IMM, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0);
    @(negedge clk); in_valid = 1'b0;
    checks++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 32'h100, 32'h00500093}) begin failures++; $display("FAIL addi_write got %b %h %h exp 1 00000100 00500093", mem_we, mem_addr, mem_wdata); end
    @(negedge clk);
    checks++; if ({mem_we, word_count} !== {1'b0, 16'd1}) begin failures++; $display("FAIL addi_done got %b %0d exp 0 1", mem_we, word_count); end
  endtask

  task automatic test_back_to_back;
    beat(FMT_S, OP_STORE, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0);
    @(negedge clk);
    checks++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 32'h104, 32'h0020A423}) begin failures++; $display("FAIL sw_write got %b %h %h exp 1 00000104 0020a423", mem_we, mem_addr, mem_wdata); end
    beat(FMT_B, OP_BRANCH, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC, 1'b0);
    @(negedge clk); in_valid = 1'b0;
    checks++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 32'h108, 32'hFE000EE3}) begin failures++; $display("FAIL beq_write got %b %h %h exp 1 00000108 fe000ee3", mem_we, mem_addr, mem_wdata); end
    @(negedge clk);
    checks++; if ({mem_we, word_count} !== {1'b0, 16'd3}) begin failures++; $display("FAIL b2b_count got %b %0d exp 0 3", mem_we, word_count); end
  endtask

  task automatic test_stall;
    mem_ready = 1'b0;
    beat(FMT_J, OP_JAL, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd8, 1'b0);
    @(negedge clk);
    beat(FMT_U, OP_LUI, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checks++; if ({mem_we, in_ready, mem_addr, mem_wdata} !== {2'b10, 32'h10C, 32'h008000EF}) begin failures++; $display("FAIL jal_hold%0d got %b%b %h %h exp 10 0000010c 008000ef", i, mem_we, in_ready, mem_addr, mem_wdata); end
      if (i < 2) @(negedge clk);
    end
    mem_ready = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    checks++; if ({mem_we, mem_addr, mem_wdata, word_count} !== {1'b1, 32'h110, 32'h123452B7, 16'd4}) begin failures++; $display("FAIL lui_write got %b %h %h %0d exp 1 00000110 123452b7 4", mem_we, mem_addr, mem_wdata, word_count); end
    @(negedge clk);
    checks++; if ({mem_we, word_count} !== {1'b0, 16'd5}) begin failures++; $display("FAIL stall_count got %b %0d exp 0 5", mem_we, word_count); end
  endtask

  task automatic test_reject;
    beat(FMT_B, OP_BRANCH, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd5, 1'b0);
    @(negedge clk);
    checks++; if ({err, mem_we, err_count} !== {2'b10, 16'd1}) begin failures++; $display("FAIL rej_odd got %b%b %0d exp 10 1", err, mem_we, err_count); end
    beat(FMT_I, OP_IMM, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h800, 1'b0);
    @(negedge clk);
    checks++; if ({err, mem_we, err_count} !== {2'b10, 16'd2}) begin failures++; $display("FAIL rej_range got %b%b %0d exp 10 2", err, mem_we, err_count); end
    beat(3'b111, OP_OP, 3'd0, 7'd0, 5'd1, 5'd1, 5'd1, 32'd0, 1'b0);
    @(negedge clk);
    checks++; if ({err, mem_we, err_count, word_count} !== {2'b10, 16'd3, 16'd5}) begin failures++; $display("FAIL rej_fmt got %b%b %0d %0d exp 10 3 5", err, mem_we, err_count, word_count); end
    beat(FMT_R, OP_OP, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1);
    @(negedge clk); in_valid = 1'b0; in_last = 1'b0;
    checks++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 32'h114, 32'h002081B3}) begin failures++; $display("FAIL add_after_rej got %b %h %h exp 1 00000114 002081b3", mem_we, mem_addr, mem_wdata); end
    @(negedge clk);
    checks++; if ({mem_we, done, busy, in_ready} !== 4'b0010) begin failures++; $display("FAIL drain got %b exp 0010", {mem_we, done, busy, in_ready}); end
    @(negedge clk);
    checks++; if ({done, word_count, err_count} !== {1'b1, 16'd6, 16'd3}) begin failures++; $display("FAIL done_pulse got %b %0d %0d exp 1 6 3", done, word_count, err_count); end
    @(negedge clk);
    checks++; if ({done, busy, err} !== 3'b001) begin failures++; $display("FAIL idle_after got %b exp 001", {done, busy, err}); end
  endtask

  task automatic test_wrap;
    begin_session(32'hFFFFFFFE);
    checks++; if ({err, err_count, word_count} !== 33'h0) begin failures++; $display("FAIL start_clear got %b %0d %0d exp 0 0 0", err, err_count, word_count); end
    beat(FMT_I, OP_IMM, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0);
    @(negedge clk);
    checks++; if ({mem_we, mem_addr} !== {1'b1, 32'hFFFFFFFC}) begin failures++; $display("FAIL wrap_first got %b %h exp 1 fffffffc", mem_we, mem_addr); end
    beat(FMT_U, OP_LUI, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000, 1'b1);
    @(negedge clk); in_valid = 1'b0; in_last = 1'b0;
    checks++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 32'h0, 32'h123452B7}) begin failures++; $display("FAIL wrap_second got %b %h %h exp 1 00000000 123452b7", mem_we, mem_addr, mem_wdata); end
    @(negedge clk);
    checks++; if ({mem_we, done} !== 2'b00) begin failures++; $display("FAIL wrap_drain got %b exp 00", {mem_we, done}); end
    @(negedge clk);
    checks++; if ({done, word_count, err} !== {1'b1, 16'd2, 1'b0}) begin failures++; $display("FAIL wrap_done got %b %0d %b exp 1 2 0", done, word_count, err); end
  endtask

  task automatic test_reset_midwrite;
    begin_session(32'h200);
    mem_ready = 1'b0;
    beat(FMT_I, OP_IMM, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0);
    @(negedge clk); in_valid = 1'b0;
    checks++; if ({mem_we, mem_addr} !== {1'b1, 32'h200}) begin failures++; $display("FAIL pend_write got %b %h exp 1 00000200", mem_we, mem_addr); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({mem_we, in_ready, busy, done, err, mem_addr, mem_wdata, word_count, err_count} !== 101'h0) begin failures++; $display("FAIL async_reset got %b%b%b%b%b %h %h %0d %0d exp all 0", mem_we, in_ready, busy, done, err, mem_addr, mem_wdata, word_count, err_count); end
    @(negedge clk); rst_n = 1'b1; mem_ready = 1'b1;
    begin_session(32'h40);
    start = 1'b1; base_addr = 32'h80;
    beat(FMT_R, OP_OP, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1);
    @(negedge clk); in_valid = 1'b0; in_last = 1'b0; start = 1'b0;
    checks++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 32'h40, 32'h002081B3}) begin failures++; $display("FAIL clean_write got %b %h %h exp 1 00000040 002081b3", mem_we, mem_addr, mem_wdata); end
    for (int i = 0; i < 10 && !done; i++) @(negedge clk);
    checks++; if ({done, word_count, err_count} !== {1'b1, 16'd1, 16'd0}) begin failures++; $display("FAIL clean_done got %b %0d %0d exp 1 1 0", done, word_count, err_count); end
  endtask

  initial begin
    test_reset;
    test_single_i;
    test_back_to_back;
    test_stall;
    test_reject;
    test_wrap;
    test_reset_midwrite;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
